// File: rtl/histogram_esitleme_birimi_pkg.sv
// rtl/histogram_esitleme_birimi_pkg.sv - state and mode codes shared by the histogram equaliser
package histogram_esitleme_birimi_pkg;

  typedef enum logic [2:0] {
    HE_BOSTA,
    HE_TEMIZLE,
    HE_SAY,
    HE_CDF,
    HE_ESLE,
    HE_BITTI
  } he_durum_t;

  localparam logic HE_MOD_HIST = 1'b0;
  localparam logic HE_MOD_ESLE = 1'b1;

endpackage

// File: rtl/histogram_esitleme_birimi_bellek.sv
// rtl/histogram_esitleme_birimi_bellek.sv - bin array, one write port and one combinational read port
module histogram_bellek #(
  parameter int ADRES_BIT = 8,
  parameter int VERI_BIT  = 17
) (
  input  logic                 clk_i,
  input  logic                 yaz_i,
  input  logic [ADRES_BIT-1:0] yaz_adres_i,
  input  logic [VERI_BIT-1:0]  yaz_veri_i,
  input  logic [ADRES_BIT-1:0] oku_adres_i,
  output logic [VERI_BIT-1:0]  oku_veri_o
);

  logic [VERI_BIT-1:0] hucre [2**ADRES_BIT];

  // No reset: every frame starts by clearing all cells.
  always_ff @(posedge clk_i) begin
    if (yaz_i) begin
      hucre[yaz_adres_i] <= yaz_veri_i;
    end
  end

  assign oku_veri_o = hucre[oku_adres_i];

endmodule

// File: rtl/histogram_esitleme_birimi.sv
// rtl/histogram_esitleme_birimi.sv - histogram / histogram-equalisation engine, one pixel per cycle
module histogram_esitleme_birimi
  import histogram_esitleme_birimi_pkg::*;
#(
  parameter int PIXEL_BIT  = 8,
  parameter int RESIM_LOG2 = 16,
  parameter int SAYAC_BIT  = RESIM_LOG2 + 1
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 basla_i,
  input  logic                 mod_i,
  input  logic                 etkin_i,
  input  logic [PIXEL_BIT-1:0] pixel_i,
  output logic                 etkin_o,
  output logic [SAYAC_BIT-1:0] pixel_o,
  output logic                 mesgul_o,
  output logic                 hazir_o
);

  localparam int L          = 2**PIXEL_BIT;
  localparam int CARPIM_BIT = SAYAC_BIT + PIXEL_BIT;
  localparam logic [PIXEL_BIT-1:0] SON_KOVA  = '1;
  localparam logic [SAYAC_BIT-1:0] N_PIKSEL  = SAYAC_BIT'(1) << RESIM_LOG2;
  localparam logic [SAYAC_BIT-1:0] N_EKSI_1  = N_PIKSEL - SAYAC_BIT'(1);

  he_durum_t durum_q, durum_d;
  logic                 mod_q;
  logic [PIXEL_BIT-1:0] kova_q;
  logic [SAYAC_BIT-1:0] piksel_say_q;
  logic [SAYAC_BIT-1:0] cdf_q;
  logic                 esle_etkin_q;
  logic [SAYAC_BIT-1:0] esle_deger_q;
  logic [PIXEL_BIT-1:0] lut [L];

  logic                 bel_yaz;
  logic [PIXEL_BIT-1:0] bel_yaz_adres;
  logic [SAYAC_BIT-1:0] bel_yaz_veri;
  logic [PIXEL_BIT-1:0] bel_oku_adres;
  logic [SAYAC_BIT-1:0] bel_oku_veri;

  logic [SAYAC_BIT-1:0]  cdf_yeni;
  logic [CARPIM_BIT-1:0] carpim;
  logic [CARPIM_BIT-1:0] kaydir;
  logic [PIXEL_BIT-1:0]  lut_deger;
  logic                  hist_cikis;

  // Counting is a same-cycle read-modify-write, so repeated pixels see the previous update.
  always_comb begin
    bel_yaz       = (durum_q == HE_TEMIZLE) || ((durum_q == HE_SAY) && etkin_i);
    bel_yaz_adres = (durum_q == HE_TEMIZLE) ? kova_q : pixel_i;
    bel_yaz_veri  = (durum_q == HE_TEMIZLE) ? '0 : bel_oku_veri + SAYAC_BIT'(1);
    bel_oku_adres = (durum_q == HE_CDF) ? kova_q : pixel_i;
  end

  histogram_bellek #(
    .ADRES_BIT (PIXEL_BIT),
    .VERI_BIT  (SAYAC_BIT)
  ) u_bellek (
    .clk_i       (clk_i),
    .yaz_i       (bel_yaz),
    .yaz_adres_i (bel_yaz_adres),
    .yaz_veri_i  (bel_yaz_veri),
    .oku_adres_i (bel_oku_adres),
    .oku_veri_o  (bel_oku_veri)
  );

  // Full-width product before the shift; clamp guards the cdf == N corner.
  always_comb begin
    cdf_yeni  = cdf_q + bel_oku_veri;
    carpim    = CARPIM_BIT'(cdf_yeni) * CARPIM_BIT'(SON_KOVA);
    kaydir    = carpim >> RESIM_LOG2;
    lut_deger = (kaydir > CARPIM_BIT'(SON_KOVA)) ? SON_KOVA : kaydir[PIXEL_BIT-1:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      durum_q <= HE_BOSTA;
    end else begin
      durum_q <= durum_d;
    end
  end

  always_comb begin
    durum_d    = durum_q;
    mesgul_o   = (durum_q != HE_BOSTA);
    hazir_o    = (durum_q == HE_BITTI);
    hist_cikis = (durum_q == HE_CDF) && (mod_q == HE_MOD_HIST);
    etkin_o    = hist_cikis | esle_etkin_q;
    pixel_o    = hist_cikis ? bel_oku_veri : esle_deger_q;
    case (durum_q)
      HE_BOSTA:   if (basla_i) durum_d = HE_TEMIZLE;
      HE_TEMIZLE: if (kova_q == SON_KOVA) durum_d = HE_SAY;
      HE_SAY:     if (etkin_i && (piksel_say_q == N_EKSI_1)) durum_d = HE_CDF;
      HE_CDF:     if (kova_q == SON_KOVA) durum_d = (mod_q == HE_MOD_ESLE) ? HE_ESLE : HE_BITTI;
      HE_ESLE:    if (piksel_say_q == N_PIKSEL) durum_d = HE_BITTI;
      HE_BITTI:   durum_d = HE_BOSTA;
      default:    durum_d = HE_BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      mod_q        <= HE_MOD_HIST;
      kova_q       <= '0;
      piksel_say_q <= '0;
      cdf_q        <= '0;
      esle_etkin_q <= 1'b0;
      esle_deger_q <= '0;
    end else begin
      esle_etkin_q <= 1'b0;
      esle_deger_q <= '0;
      case (durum_q)
        HE_BOSTA: begin
          if (basla_i) mod_q <= mod_i;
          kova_q       <= '0;
          piksel_say_q <= '0;
          cdf_q        <= '0;
        end
        HE_TEMIZLE: kova_q <= kova_q + PIXEL_BIT'(1);
        HE_SAY: begin
          if (etkin_i) piksel_say_q <= piksel_say_q + SAYAC_BIT'(1);
        end
        HE_CDF: begin
          kova_q <= kova_q + PIXEL_BIT'(1);
          cdf_q  <= cdf_yeni;
          if (kova_q == SON_KOVA) piksel_say_q <= '0;
        end
        HE_ESLE: begin
          // Once N pixels are in, the last output is on the port and further input is dropped.
          if (etkin_i && (piksel_say_q != N_PIKSEL)) begin
            piksel_say_q <= piksel_say_q + SAYAC_BIT'(1);
            esle_etkin_q <= 1'b1;
            esle_deger_q <= SAYAC_BIT'(lut[pixel_i]);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (durum_q == HE_CDF) begin
      lut[kova_q] <= lut_deger;
    end
  end

endmodule

// File: tb/tb_histogram_esitleme_birimi.sv
// tb/tb_histogram_esitleme_birimi.sv - directed self-checking bench for histogram_esitleme_birimi
module tb_histogram_esitleme_birimi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn;
  logic       basla_a, mod_a, etkin_ai;
  logic [7:0] pixel_ai;
  logic       etkin_ao, mesgul_a, hazir_a;
  logic [4:0] pixel_ao;
  logic       basla_b, mod_b, etkin_bi;
  logic [7:0] pixel_bi;
  logic       etkin_bo, mesgul_b, hazir_b;
  logic [8:0] pixel_bo;

  int n_cmp = 0;
  int n_err = 0;
  int a_pix   [0:31];
  int exp_bin [0:255];

  // N = 16 instance for histogram dumps
  histogram_esitleme_birimi #(.PIXEL_BIT(8), .RESIM_LOG2(4), .SAYAC_BIT(5)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .basla_i(basla_a), .mod_i(mod_a), .etkin_i(etkin_ai),
    .pixel_i(pixel_ai), .etkin_o(etkin_ao), .pixel_o(pixel_ao), .mesgul_o(mesgul_a), .hazir_o(hazir_a)
  );

  // N = 256 instance for equalisation
  histogram_esitleme_birimi #(.PIXEL_BIT(8), .RESIM_LOG2(8), .SAYAC_BIT(9)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .basla_i(basla_b), .mod_i(mod_b), .etkin_i(etkin_bi),
    .pixel_i(pixel_bi), .etkin_o(etkin_bo), .pixel_o(pixel_bo), .mesgul_o(mesgul_b), .hazir_o(hazir_b)
  );

  task automatic test_reset;
    rstn = 1'b1;
    basla_a = 0; mod_a = 0; etkin_ai = 0; pixel_ai = 0;
    basla_b = 0; mod_b = 0; etkin_bi = 0; pixel_bi = 0;
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({etkin_ao, pixel_ao, mesgul_a, hazir_a} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_a: got %b%b%b%b need all zero", etkin_ao, pixel_ao, mesgul_a, hazir_a);
    end
    n_cmp++;
    if ({etkin_bo, pixel_bo, mesgul_b, hazir_b} !== 12'd0) begin
      n_err++;
      $display("FAIL reset_b: got %b%b%b%b need all zero", etkin_bo, pixel_bo, mesgul_b, hazir_b);
    end
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({mesgul_a, mesgul_b} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: got mesgul %b%b need 00", mesgul_a, mesgul_b);
    end
  endtask

  // Mode-0 frame on dut_a; junk pixels during clearing must be ignored.
  task automatic run_a(input string ad, input int npix);
    int stray, hz, hz_cyc;
    for (int k = 0; k < 256; k++) exp_bin[k] = 0;
    for (int i = 0; i < npix && i < 16; i++) exp_bin[a_pix[i]]++;
    stray = 0; hz = 0; hz_cyc = -1;
    @(posedge clk); #1;
    basla_a = 1; mod_a = 0;
    for (int c = 1; c <= 532; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        n_cmp++;
        if (mesgul_a !== 1'b1) begin
          n_err++;
          $display("FAIL %s busy_start: got %b need 1", ad, mesgul_a);
        end
      end
      if (c >= 273 && c <= 528) begin
        n_cmp++;
        if (etkin_ao !== 1'b1 || pixel_ao !== 5'(exp_bin[c-273])) begin
          n_err++;
          $display("FAIL %s bin[%0d]: got v=%b val=%0d need v=1 val=%0d", ad, c-273, etkin_ao, pixel_ao, exp_bin[c-273]);
        end
      end else if (etkin_ao !== 1'b0 || pixel_ao !== 5'd0) begin
        stray++;
      end
      if (hazir_a === 1'b1) begin hz++; hz_cyc = c; end
      if (c == 530) begin
        n_cmp++;
        if (mesgul_a !== 1'b0) begin
          n_err++;
          $display("FAIL %s idle_end: got %b need 0", ad, mesgul_a);
        end
      end
      basla_a = 0;
      if (c < 257) begin etkin_ai = 1; pixel_ai = 8'd9; end
      else if (c - 257 < npix) begin etkin_ai = 1; pixel_ai = 8'(a_pix[c-257]); end
      else begin etkin_ai = 0; pixel_ai = 0; end
    end
    n_cmp++;
    if (stray !== 0) begin
      n_err++;
      $display("FAIL %s stray_output: got %0d cycles need 0", ad, stray);
    end
    n_cmp++;
    if (hz !== 1 || hz_cyc !== 529) begin
      n_err++;
      $display("FAIL %s hazir: got %0d pulses at %0d need 1 at 529", ad, hz, hz_cyc);
    end
  endtask

  task automatic test_single_value;
    for (int i = 0; i < 16; i++) a_pix[i] = 5;
    run_a("single_value", 16);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++) a_pix[i] = (i < 4) ? 7 : 200;
    run_a("back_to_back", 16);
  endtask

  task automatic test_extra_pixels;
    for (int i = 0; i < 20; i++) a_pix[i] = (i < 8) ? 255 : (i < 16) ? 0 : 3;
    run_a("extra_pixels", 20);
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    basla_a = 1; mod_a = 0;
    for (int c = 1; c <= 262; c++) begin
      @(posedge clk); #1;
      basla_a = 0;
      if (c >= 257) begin etkin_ai = 1; pixel_ai = 8'd2; end
    end
    #2 rstn = 1'b0;
    #1;
    n_cmp++;
    if ({etkin_ao, pixel_ao, mesgul_a, hazir_a} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_mid: got %b%b%b%b need all zero", etkin_ao, pixel_ao, mesgul_a, hazir_a);
    end
    etkin_ai = 0; pixel_ai = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 16; i++) a_pix[i] = 100;
    run_a("after_reset", 16);
  endtask

  // Uniform frame, then reversed second pass; basla pulses during ESLE must be ignored.
  task automatic test_equalise;
    int stray, hz, hz_cyc, p, ex;
    stray = 0; hz = 0; hz_cyc = -1;
    @(posedge clk); #1;
    basla_b = 1; mod_b = 1;
    for (int c = 1; c <= 1032; c++) begin
      @(posedge clk); #1;
      if (c >= 770 && c <= 1025) begin
        p  = 255 - (c - 770);
        ex = ((p + 1) * 255) >> 8;
        n_cmp++;
        if (etkin_bo !== 1'b1 || pixel_bo !== 9'(ex)) begin
          n_err++;
          $display("FAIL equalise lut[%0d]: got v=%b val=%0d need v=1 val=%0d", p, etkin_bo, pixel_bo, ex);
        end
      end else if (etkin_bo !== 1'b0 || pixel_bo !== 9'd0) begin
        stray++;
      end
      if (hazir_b === 1'b1) begin hz++; hz_cyc = c; end
      if (c == 1032) begin
        n_cmp++;
        if (mesgul_b !== 1'b0) begin
          n_err++;
          $display("FAIL equalise idle_end: got %b need 0", mesgul_b);
        end
      end
      mod_b   = 0;
      basla_b = (c >= 800 && c <= 820);
      if (c >= 257 && c < 513) begin etkin_bi = 1; pixel_bi = 8'(c - 257); end
      else if (c >= 769 && c < 1025) begin etkin_bi = 1; pixel_bi = 8'(255 - (c - 769)); end
      else begin etkin_bi = 0; pixel_bi = 0; end
    end
    n_cmp++;
    if (stray !== 0) begin
      n_err++;
      $display("FAIL equalise stray_output: got %0d cycles need 0", stray);
    end
    n_cmp++;
    if (hz !== 1 || hz_cyc !== 1026) begin
      n_err++;
      $display("FAIL equalise hazir: got %0d pulses at %0d need 1 at 1026", hz, hz_cyc);
    end
  endtask

  initial begin
    test_reset();
    test_single_value();
    test_back_to_back();
    test_extra_pixels();
    test_reset_mid();
    test_equalise();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
